// File: rtl/trg_sci_pkt_gen_if.sv
// Signal bundle between the trigger logic / readout side and the science packet generator.
interface trg_sci_pkt_gen_if #(
    parameter int N_MODES = 6,
    parameter int FIFO_AW = 8
);
    logic [8*N_MODES-1:0] trg_mode_in;
    logic [15:0]          hit_sig_stus_in;
    logic [15:0]          eff_trg_cnt_in;
    logic [23:0]          trg_busy_time_cnt_in;
    logic                 coincid_trg_in;
    logic                 fifo_rd_in;
    logic [7:0]           fifo_data_out;
    logic                 fifo_empty_out;
    logic [FIFO_AW:0]     fifo_level_out;
    logic                 busy_out;
    logic [15:0]          seq_cnt_out;
    logic [15:0]          drop_cnt_out;

    modport master (
        output trg_mode_in, hit_sig_stus_in, eff_trg_cnt_in, trg_busy_time_cnt_in,
               coincid_trg_in, fifo_rd_in,
        input  fifo_data_out, fifo_empty_out, fifo_level_out, busy_out,
               seq_cnt_out, drop_cnt_out
    );

    modport slave (
        input  trg_mode_in, hit_sig_stus_in, eff_trg_cnt_in, trg_busy_time_cnt_in,
               coincid_trg_in, fifo_rd_in,
        output fifo_data_out, fifo_empty_out, fifo_level_out, busy_out,
               seq_cnt_out, drop_cnt_out
    );
endinterface

// File: rtl/trg_sci_pkt_gen.sv
// Trigger science-data packetiser: snapshots trigger fields into a 15-byte CRC-16 packet
// and stores it whole into an internal byte FIFO, dropping triggers that do not fit.
module trg_sci_pkt_gen #(
    parameter int          N_MODES  = 6,
    parameter int          FIFO_AW  = 8,
    parameter logic [15:0] HEADER   = 16'hEB90,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    trg_sci_pkt_gen_if.slave  bus
);
    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_LV = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   LVL_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_CRC_HI = 2'd2;
    localparam logic [1:0] ST_CRC_LO = 2'd3;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int b = 7; b >= 0; b--) begin
            if (c[15] ^ data[b]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [1:0]          state_q;
    logic [3:0]          byte_idx_q;
    logic [15:0]         crc_q;
    logic [15:0]         sel_q, sel_d;
    logic [15:0]         seq_q, drop_q;
    logic [15:0]         cap_seq_q, cap_sel_q, cap_hit_q, cap_eff_q;
    logic [23:0]         cap_busy_q;
    logic [7:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    level_q, level_d, free_s;
    logic [7:0]          data_q;
    logic                space_ok_s, drop_inc_s, wr_en_s, rd_en_s;
    logic [7:0]          pkt_byte_s, wr_byte_s;

    // Priority mode select: lowest enabled index wins
    always_comb begin
        sel_d = 16'h0000;
        for (int i = N_MODES - 1; i >= 0; i--) begin
            if (bus.trg_mode_in[8*i+6 +: 2] == 2'b01) begin
                sel_d = {8'h80 >> i, bus.trg_mode_in[8*i +: 8]};
            end else begin
                sel_d = sel_d;
            end
        end
    end

    // Space check and drop decision
    always_comb begin
        free_s     = DEPTH_LV - level_q;
        space_ok_s = ({{(31-FIFO_AW){1'b0}}, free_s} >= 32'd15);
        drop_inc_s = bus.coincid_trg_in && ((state_q != ST_IDLE) || !space_ok_s);
    end

    // Packet byte selection for the WRITE phase
    always_comb begin
        case (byte_idx_q)
            4'd0:    pkt_byte_s = HEADER[15:8];
            4'd1:    pkt_byte_s = HEADER[7:0];
            4'd2:    pkt_byte_s = cap_seq_q[15:8];
            4'd3:    pkt_byte_s = cap_seq_q[7:0];
            4'd4:    pkt_byte_s = cap_sel_q[15:8];
            4'd5:    pkt_byte_s = cap_sel_q[7:0];
            4'd6:    pkt_byte_s = cap_hit_q[15:8];
            4'd7:    pkt_byte_s = cap_hit_q[7:0];
            4'd8:    pkt_byte_s = cap_eff_q[15:8];
            4'd9:    pkt_byte_s = cap_eff_q[7:0];
            4'd10:   pkt_byte_s = cap_busy_q[23:16];
            4'd11:   pkt_byte_s = cap_busy_q[15:8];
            4'd12:   pkt_byte_s = cap_busy_q[7:0];
            default: pkt_byte_s = 8'h00;
        endcase
    end

    // FIFO write port driven by the FSM state
    always_comb begin
        wr_en_s   = 1'b0;
        wr_byte_s = 8'h00;
        case (state_q)
            ST_WRITE:  begin wr_en_s = 1'b1; wr_byte_s = pkt_byte_s;  end
            ST_CRC_HI: begin wr_en_s = 1'b1; wr_byte_s = crc_q[15:8]; end
            ST_CRC_LO: begin wr_en_s = 1'b1; wr_byte_s = crc_q[7:0];  end
            default:   begin wr_en_s = 1'b0; wr_byte_s = 8'h00;       end
        endcase
    end

    // FIFO read qualification and level update
    always_comb begin
        rd_en_s = bus.fifo_rd_in && (level_q != {(FIFO_AW+1){1'b0}});
        case ({wr_en_s, rd_en_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Packet FSM, field capture, CRC accumulation and counters
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 4'd0;
            crc_q      <= 16'h0000;
            sel_q      <= 16'h0000;
            seq_q      <= 16'h0000;
            drop_q     <= 16'h0000;
            cap_seq_q  <= 16'h0000;
            cap_sel_q  <= 16'h0000;
            cap_hit_q  <= 16'h0000;
            cap_eff_q  <= 16'h0000;
            cap_busy_q <= 24'h000000;
        end else begin
            sel_q <= sel_d;
            if (drop_inc_s && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.coincid_trg_in && space_ok_s) begin
                        cap_seq_q  <= seq_q;
                        cap_sel_q  <= sel_q;
                        cap_hit_q  <= bus.hit_sig_stus_in;
                        cap_eff_q  <= bus.eff_trg_cnt_in;
                        cap_busy_q <= bus.trg_busy_time_cnt_in;
                        seq_q      <= seq_q + 16'd1;
                        crc_q      <= CRC_INIT;
                        byte_idx_q <= 4'd0;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Header bytes are outside CRC coverage
                    if (byte_idx_q >= 4'd2) begin
                        crc_q <= crc16_byte(crc_q, pkt_byte_s);
                    end
                    if (byte_idx_q == 4'd12) begin
                        state_q <= ST_CRC_HI;
                    end else begin
                        byte_idx_q <= byte_idx_q + 4'd1;
                    end
                end
                ST_CRC_HI: state_q <= ST_CRC_LO;
                ST_CRC_LO: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO pointers, level and registered read data
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= {FIFO_AW{1'b0}};
            rd_ptr_q <= {FIFO_AW{1'b0}};
            level_q  <= {(FIFO_AW+1){1'b0}};
            data_q   <= 8'h00;
        end else begin
            level_q <= level_d;
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                data_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    // FIFO storage array
    always_ff @(posedge clk_in) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_byte_s;
        end
    end

    assign bus.fifo_data_out  = data_q;
    assign bus.fifo_empty_out = (level_q == {(FIFO_AW+1){1'b0}});
    assign bus.fifo_level_out = level_q;
    assign bus.busy_out       = (state_q != ST_IDLE);
    assign bus.seq_cnt_out    = seq_q;
    assign bus.drop_cnt_out   = drop_q;
endmodule

// File: tb/tb_trg_sci_pkt_gen.sv
// Directed bench for trg_sci_pkt_gen: a default-size instance plus a 32-byte FIFO instance.
module tb_trg_sci_pkt_gen;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] exp_pkt [15];
    logic [7:0] got [20];
    int   n_got;
    logic [8:0] lvl_before;

    always #10 clk = ~clk;

    trg_sci_pkt_gen_if #(.N_MODES(6), .FIFO_AW(8)) bus_a ();
    trg_sci_pkt_gen_if #(.N_MODES(6), .FIFO_AW(5)) bus_b ();

    trg_sci_pkt_gen #(.N_MODES(6), .FIFO_AW(8)) dut_a (.clk_in(clk), .rst_in(rst_a), .bus(bus_a.slave));
    trg_sci_pkt_gen #(.N_MODES(6), .FIFO_AW(5)) dut_b (.clk_in(clk), .rst_in(rst_b), .bus(bus_b.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected packet, CRC computed over the 88-bit payload bit by bit
    task automatic make_pkt(input logic [15:0] seq, input logic [15:0] sel, input logic [15:0] hit,
                            input logic [15:0] eff, input logic [23:0] bsy);
        logic [87:0] msg;
        logic [15:0] crc;
        logic        fb;
        msg = {seq, sel, hit, eff, bsy};
        crc = 16'hFFFF;
        for (int b = 87; b >= 0; b--) begin
            fb  = crc[15] ^ msg[b];
            crc = {crc[14:0], 1'b0};
            if (fb) crc = crc ^ 16'h1021;
        end
        exp_pkt[0] = 8'hEB;
        exp_pkt[1] = 8'h90;
        for (int k = 0; k < 11; k++) exp_pkt[2+k] = msg[87-8*k -: 8];
        exp_pkt[13] = crc[15:8];
        exp_pkt[14] = crc[7:0];
    endtask

    task automatic pulse_a;
        bus_a.coincid_trg_in = 1'b1;
        tick(1);
        bus_a.coincid_trg_in = 1'b0;
    endtask

    task automatic pulse_b;
        bus_b.coincid_trg_in = 1'b1;
        tick(1);
        bus_b.coincid_trg_in = 1'b0;
    endtask

    task automatic read_pkt_a(input string tag);
        for (int j = 0; j < 15; j++) begin
            bus_a.fifo_rd_in = 1'b1;
            tick(1);
            check($sformatf("%s_byte%0d", tag, j), {24'h0, bus_a.fifo_data_out}, {24'h0, exp_pkt[j]});
        end
        bus_a.fifo_rd_in = 1'b0;
    endtask

    task automatic set_fields_a(input logic [47:0] mode, input logic [15:0] hit,
                                input logic [15:0] eff, input logic [23:0] bsy);
        bus_a.trg_mode_in          = mode;
        bus_a.hit_sig_stus_in      = hit;
        bus_a.eff_trg_cnt_in       = eff;
        bus_a.trg_busy_time_cnt_in = bsy;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_fields_a(48'h0, 16'h0, 16'h0, 24'h0);
        bus_a.coincid_trg_in = 1'b0;
        bus_a.fifo_rd_in     = 1'b0;
        bus_b.trg_mode_in          = 48'h0000_0000_0040;
        bus_b.hit_sig_stus_in      = 16'h1111;
        bus_b.eff_trg_cnt_in       = 16'h2222;
        bus_b.trg_busy_time_cnt_in = 24'h333333;
        bus_b.coincid_trg_in = 1'b0;
        bus_b.fifo_rd_in     = 1'b0;
        tick(2);

        // Reset state
        check("rst_empty", {31'h0, bus_a.fifo_empty_out}, 32'd1);
        check("rst_data",  {24'h0, bus_a.fifo_data_out}, 32'd0);
        check("rst_busy",  {31'h0, bus_a.busy_out}, 32'd0);
        check("rst_seq",   {16'h0, bus_a.seq_cnt_out}, 32'd0);
        check("rst_drop",  {16'h0, bus_a.drop_cnt_out}, 32'd0);
        check("rst_level", {23'h0, bus_a.fifo_level_out}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(1);

        // Mode byte 1 = 0x45
        set_fields_a({8'h00, 8'h00, 8'h00, 8'h00, 8'h45, 8'h00}, 16'h1234, 16'h0007, 24'hABCDEF);
        tick(2);
        pulse_a();
        check("t1_busy", {31'h0, bus_a.busy_out}, 32'd1);
        tick(15);
        check("t1_idle",  {31'h0, bus_a.busy_out}, 32'd0);
        check("t1_level", {23'h0, bus_a.fifo_level_out}, 32'd15);
        check("t1_seq",   {16'h0, bus_a.seq_cnt_out}, 32'd1);
        make_pkt(16'h0000, 16'h4045, 16'h1234, 16'h0007, 24'hABCDEF);
        read_pkt_a("t1");

        // Bytes 2 and 4 enabled: byte 2 wins
        set_fields_a({8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 8'h00}, 16'hBEEF, 16'h0100, 24'h000102);
        tick(2);
        pulse_a();
        tick(15);
        make_pkt(16'h0001, 16'h2040, 16'hBEEF, 16'h0100, 24'h000102);
        read_pkt_a("t2a");

        // No enabled mode byte
        set_fields_a({8'h80, 8'hC0, 8'h00, 8'h80, 8'hC0, 8'h00}, 16'hBEEF, 16'h0100, 24'h000102);
        tick(2);
        pulse_a();
        tick(15);
        make_pkt(16'h0002, 16'h0000, 16'hBEEF, 16'h0100, 24'h000102);
        read_pkt_a("t2b");
        check("t2_seq", {16'h0, bus_a.seq_cnt_out}, 32'd3);

        // Trigger while busy is dropped; T+16 is accepted
        pulse_a();
        tick(4);
        pulse_a();
        check("t4_drop", {16'h0, bus_a.drop_cnt_out}, 32'd1);
        tick(10);
        check("t4_idle",  {31'h0, bus_a.busy_out}, 32'd0);
        check("t4_level", {23'h0, bus_a.fifo_level_out}, 32'd15);
        pulse_a();
        check("t4_busy2", {31'h0, bus_a.busy_out}, 32'd1);
        check("t4_seq",   {16'h0, bus_a.seq_cnt_out}, 32'd5);
        tick(15);
        check("t4_level2", {23'h0, bus_a.fifo_level_out}, 32'd30);
        check("t4_drop2",  {16'h0, bus_a.drop_cnt_out}, 32'd1);
        make_pkt(16'h0003, 16'h0000, 16'hBEEF, 16'h0100, 24'h000102);
        read_pkt_a("t4p1");
        make_pkt(16'h0004, 16'h0000, 16'hBEEF, 16'h0100, 24'h000102);
        read_pkt_a("t4p2");

        // Reset in the middle of a packet
        pulse_a();
        tick(6);
        rst_a = 1'b1;
        #1;
        check("t5_empty", {31'h0, bus_a.fifo_empty_out}, 32'd1);
        check("t5_level", {23'h0, bus_a.fifo_level_out}, 32'd0);
        check("t5_busy",  {31'h0, bus_a.busy_out}, 32'd0);
        check("t5_seq",   {16'h0, bus_a.seq_cnt_out}, 32'd0);
        check("t5_drop",  {16'h0, bus_a.drop_cnt_out}, 32'd0);
        tick(1);
        rst_a = 1'b0;
        set_fields_a({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F}, 16'h0000, 16'hFFFF, 24'h5A5A5A);
        tick(2);
        pulse_a();
        tick(15);
        check("t5_level2", {23'h0, bus_a.fifo_level_out}, 32'd15);
        check("t5_seq2",   {16'h0, bus_a.seq_cnt_out}, 32'd1);
        make_pkt(16'h0000, 16'h807F, 16'h0000, 16'hFFFF, 24'h5A5A5A);
        read_pkt_a("t5");

        // Continuous reading while the packet is written
        set_fields_a({8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 16'hA5A5, 16'h1234, 24'h010203);
        tick(2);
        bus_a.fifo_rd_in = 1'b1;
        pulse_a();
        n_got = 0;
        for (int c = 0; c < 20; c++) begin
            lvl_before = bus_a.fifo_level_out;
            tick(1);
            if (lvl_before != 9'd0 && n_got < 20) begin
                got[n_got] = bus_a.fifo_data_out;
                n_got++;
            end
        end
        check("t6_count", n_got, 32'd15);
        make_pkt(16'h0001, 16'h0441, 16'hA5A5, 16'h1234, 24'h010203);
        for (int j = 0; j < 15; j++) begin
            check($sformatf("t6_byte%0d", j), {24'h0, got[j]}, {24'h0, exp_pkt[j]});
        end
        tick(3);
        check("t6_hold",  {24'h0, bus_a.fifo_data_out}, {24'h0, exp_pkt[14]});
        check("t6_empty", {31'h0, bus_a.fifo_empty_out}, 32'd1);
        check("t6_level", {23'h0, bus_a.fifo_level_out}, 32'd0);
        bus_a.fifo_rd_in = 1'b0;

        // 32-byte FIFO: third trigger does not fit
        pulse_b();
        tick(19);
        pulse_b();
        tick(19);
        pulse_b();
        tick(16);
        check("t3_level", {26'h0, bus_b.fifo_level_out}, 32'd30);
        check("t3_seq",   {16'h0, bus_b.seq_cnt_out}, 32'd2);
        check("t3_drop",  {16'h0, bus_b.drop_cnt_out}, 32'd1);
        bus_b.fifo_rd_in = 1'b1;
        tick(15);
        bus_b.fifo_rd_in = 1'b0;
        check("t3_level_rd", {26'h0, bus_b.fifo_level_out}, 32'd15);
        pulse_b();
        tick(15);
        check("t3_level2", {26'h0, bus_b.fifo_level_out}, 32'd30);
        check("t3_seq2",   {16'h0, bus_b.seq_cnt_out}, 32'd3);
        check("t3_drop2",  {16'h0, bus_b.drop_cnt_out}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
